// File: rtl/qsched_pkg.sv
// Shared types for the timestamp-ordered dispatch buffer: instruction layout,
// FSM encoding and operand-overlap helper used when QSCHED_QUBIT_CONFLICT_EN is defined.
package qsched_pkg;

  localparam int NUM_FPGA           = 64;
  localparam int NUM_QUBIT_PER_FPGA = 64;
  localparam int TS_W               = 16;

  function automatic int qubit_width(input int n_fpga, input int n_qubit);
    return $clog2(n_fpga * n_qubit);
  endfunction

  localparam int QW = qubit_width(NUM_FPGA, NUM_QUBIT_PER_FPGA);
  localparam int IW = 2 + 3 * QW + TS_W;

  typedef enum logic [1:0] {
    OP_1Q   = 2'd0,
    OP_2Q   = 2'd1,
    OP_MEAS = 2'd2,
    OP_NOP  = 2'd3
  } op_code_e;

  typedef struct packed {
    op_code_e            op_code;
    logic [QW-1:0]       op_1;
    logic [QW-1:0]       op_2;
    logic [QW-1:0]       dest;
    logic [TS_W-1:0]     start_time;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // NOP carries no operands, so it never shares a qubit with anything.
  function automatic logic shares_qubit(input instr_t a, input instr_t b);
    logic [2:0][QW-1:0] qa;
    logic [2:0][QW-1:0] qb;
    logic               hit;
    qa  = {a.op_1, a.op_2, a.dest};
    qb  = {b.op_1, b.op_2, b.dest};
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        hit = hit | (qa[i] == qb[j]);
      end
    end
    return hit & (a.op_code != OP_NOP) & (b.op_code != OP_NOP);
  endfunction

endpackage

// File: rtl/qsched_ts_dispatch_if.sv
// Instruction-in and dispatch-out handshake bundle; master is the producer/consumer
// side, slave is the dispatch buffer.
interface qsched_ts_dispatch_if #(
  parameter int NUM_PORTS = 4,
  parameter int IW        = qsched_pkg::IW
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IW-1:0]          in_instr;
  logic [NUM_PORTS-1:0]   dsp_valid;
  logic [NUM_PORTS-1:0]   dsp_ready;
  logic [NUM_PORTS*IW-1:0] dsp_instr;

  modport master (
    output in_valid, in_instr, dsp_ready,
    input  in_ready, dsp_valid, dsp_instr
  );

  modport slave (
    input  in_valid, in_instr, dsp_ready,
    output in_ready, dsp_valid, dsp_instr
  );
endinterface

// File: rtl/qsched_pick.sv
// Combinational priority selector: hands issuable entries to ports in index order.
// With QSCHED_QUBIT_CONFLICT_EN, entries sharing a qubit with a lower port are skipped.
module qsched_pick
  import qsched_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_PORTS = 4
) (
  input  logic [DEPTH-1:0]     i_issuable,
`ifdef QSCHED_QUBIT_CONFLICT_EN
  input  instr_t               i_entries [DEPTH],
`endif
  output logic [DEPTH-1:0]     o_sel [NUM_PORTS],
  output logic [NUM_PORTS-1:0] o_port_valid
);

  // Walk entries lowest-first, giving each accepted candidate the next free port.
  always_comb begin
    int   w_cnt;
    logic w_ok;
`ifdef QSCHED_QUBIT_CONFLICT_EN
    logic [DEPTH-1:0] w_placed;
    w_placed = '0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_sel[p] = '0;
    end
    o_port_valid = '0;
    w_cnt        = 0;
    w_ok         = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
`ifdef QSCHED_QUBIT_CONFLICT_EN
      w_ok = i_issuable[e];
      for (int f = 0; f < e; f++) begin
        w_ok = w_ok & ~(w_placed[f] & shares_qubit(i_entries[f], i_entries[e]));
      end
`else
      w_ok = i_issuable[e];
`endif
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_ok && (p == w_cnt)) begin
          o_sel[p][e]     = 1'b1;
          o_port_valid[p] = 1'b1;
        end else begin
          o_sel[p][e]     = o_sel[p][e];
        end
      end
      if (w_ok && (w_cnt < NUM_PORTS)) begin
`ifdef QSCHED_QUBIT_CONFLICT_EN
        w_placed[e] = 1'b1;
`endif
        w_cnt = w_cnt + 1;
      end else begin
        w_cnt = w_cnt;
      end
    end
  end

endmodule

// File: rtl/qsched_ts_dispatch.sv
// Timestamp-ordered multi-port dispatch buffer (IDLE/SEEK/ISSUE timestamp FSM).
// Optional qubit-conflict skipping is enabled by defining QSCHED_QUBIT_CONFLICT_EN.
module qsched_ts_dispatch
  import qsched_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_PORTS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  qsched_ts_dispatch_if.slave     bus,
  output logic [TS_W-1:0]         o_curr_ts,
  output logic [$clog2(DEPTH):0]  o_occupancy,
  output logic                    o_busy
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(DEPTH);

  instr_t                  r_mem [DEPTH];
  logic [DEPTH-1:0]        r_valid;
  state_e                  r_state;
  logic [TS_W-1:0]         r_curr_ts;
  logic [OW-1:0]           r_occ;

  instr_t                  w_in;
  logic                    w_in_ready;
  logic                    w_acc;
  logic                    w_acc_match;
  logic [SW-1:0]           w_slot;
  logic [DEPTH-1:0]        w_issuable;
  logic [DEPTH-1:0]        w_free;
  logic [DEPTH-1:0]        w_set;
  logic [DEPTH-1:0]        w_left;
  logic [DEPTH-1:0]        w_sel [NUM_PORTS];
  logic [NUM_PORTS-1:0]    w_pv;
  logic [OW-1:0]           w_nfree;
  logic [OW-1:0]           w_occ_nxt;
  logic [TS_W-1:0]         w_min_ts;
  logic [NUM_PORTS*IW-1:0] w_dsp_instr;

  assign w_in        = instr_t'(bus.in_instr);
  assign w_in_ready  = (r_occ < OW'(DEPTH));
  assign w_acc       = bus.in_valid & w_in_ready;
  assign w_acc_match = w_acc & (w_in.start_time <= r_curr_ts);

  // Issuable mask, lowest free slot and earliest pending timestamp.
  always_comb begin
    w_issuable = '0;
    w_slot     = '0;
    w_min_ts   = '1;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      w_issuable[e] = r_valid[e] & (r_mem[e].start_time <= r_curr_ts) & (r_state == ST_ISSUE);
      if (!r_valid[e]) begin
        w_slot = SW'(e);
      end else begin
        w_slot = w_slot;
      end
      if (r_valid[e] && (r_mem[e].start_time < w_min_ts)) begin
        w_min_ts = r_mem[e].start_time;
      end else begin
        w_min_ts = w_min_ts;
      end
    end
  end

  qsched_pick #(
    .DEPTH      (DEPTH),
    .NUM_PORTS  (NUM_PORTS)
  ) u_pick (
    .i_issuable   (w_issuable),
`ifdef QSCHED_QUBIT_CONFLICT_EN
    .i_entries    (r_mem),
`endif
    .o_sel        (w_sel),
    .o_port_valid (w_pv)
  );

  // Port muxing plus the per-entry free/set vectors for this cycle's handshakes.
  always_comb begin
    w_free      = '0;
    w_set       = '0;
    w_nfree     = '0;
    w_dsp_instr = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_free[e] = w_free[e] | (w_sel[p][e] & bus.dsp_ready[p]);
        w_dsp_instr[p*IW +: IW] = w_dsp_instr[p*IW +: IW] | (r_mem[e] & {IW{w_sel[p][e]}});
      end
      w_set[e] = w_acc & (w_slot == SW'(e));
      w_nfree  = w_nfree + OW'(w_free[e]);
    end
    w_left    = w_issuable & ~w_free;
    w_occ_nxt = r_occ + OW'(w_acc) - w_nfree;
  end

  // Storage, occupancy and the monotonic-timestamp FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
      r_valid   <= '0;
      r_state   <= ST_IDLE;
      r_curr_ts <= '0;
      r_occ     <= '0;
    end else begin
      if (w_acc) begin
        r_mem[w_slot] <= w_in;
      end
      r_valid <= (r_valid & ~w_free) | w_set;
      r_occ   <= w_occ_nxt;
      case (r_state)
        ST_IDLE: begin
          r_state <= w_acc ? ST_SEEK : ST_IDLE;
        end
        ST_SEEK: begin
          if (w_min_ts > r_curr_ts) begin
            r_curr_ts <= w_min_ts;
          end
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Stay while anything (including a late arrival accepted now) still matches.
          if ((|w_left) || w_acc_match) begin
            r_state <= ST_ISSUE;
          end else if (w_occ_nxt != '0) begin
            r_state <= ST_SEEK;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.dsp_valid = w_pv;
  assign bus.dsp_instr = w_dsp_instr;
  assign o_curr_ts     = r_curr_ts;
  assign o_occupancy   = r_occ;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qsched_ts_dispatch.sv
// Self-checking bench for qsched_ts_dispatch: directed scenarios plus randomized
// traffic against a slot-array reference model (honours QSCHED_QUBIT_CONFLICT_EN).
module tb_qsched_ts_dispatch;
  import qsched_pkg::*;

  localparam int DEPTH = 16;
  localparam int NP    = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [TS_W-1:0] curr_ts;
  logic [OW-1:0]   occ;
  logic            busy;
  int              n_tests = 0;
  int              n_fail  = 0;

  qsched_ts_dispatch_if #(.NUM_PORTS(NP), .IW(IW)) bus ();

  qsched_ts_dispatch #(.DEPTH(DEPTH), .NUM_PORTS(NP)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_curr_ts   (curr_ts),
    .o_occupancy (occ),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input op_code_e op, input int a, input int b, input int d, input int ts);
    instr_t r;
    r.op_code    = op;
    r.op_1       = QW'(a);
    r.op_2       = QW'(b);
    r.dest       = QW'(d);
    r.start_time = TS_W'(ts);
    return r;
  endfunction

`ifdef QSCHED_QUBIT_CONFLICT_EN
  function automatic bit tb_overlap(input instr_t a, input instr_t b);
    logic [QW-1:0] sa [3];
    logic [QW-1:0] sb [3];
    if (a.op_code == OP_NOP || b.op_code == OP_NOP) return 1'b0;
    sa = '{a.op_1, a.op_2, a.dest};
    sb = '{b.op_1, b.op_2, b.dest};
    foreach (sa[i]) foreach (sb[j]) if (sa[i] == sb[j]) return 1'b1;
    return 1'b0;
  endfunction
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input instr_t w, input logic [NP-1:0] rdy);
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.dsp_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_tests++; if (bus.dsp_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.dsp_valid); end
    n_tests++; if (bus.dsp_instr !== '0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.dsp_instr); end
    n_tests++; if (curr_ts !== '0) begin n_fail++; $display("FAIL reset_ts got %0d want 0", curr_ts); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    instr_t w;
    do_reset();
    w = mk(OP_1Q, 5, 5, 5, 10);
    drive(1'b1, w, '1);
    tick();
    drive(1'b0, '0, '1);
    n_tests++; if (bus.dsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_seek_valid got %b want 0000", bus.dsp_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    n_tests++; if (bus.dsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid got %b want 0001", bus.dsp_valid); end
    n_tests++; if (bus.dsp_instr[IW-1:0] !== w) begin n_fail++; $display("FAIL single_instr got %h want %h", bus.dsp_instr[IW-1:0], w); end
    n_tests++; if (curr_ts !== 16'd10) begin n_fail++; $display("FAIL single_ts got %0d want 10", curr_ts); end
    tick();
    n_tests++; if (occ !== '0) begin n_fail++; $display("FAIL single_occ got %0d want 0", occ); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", busy); end
  endtask

  task automatic test_order();
    instr_t          wa, w30, w20a, w20b, w40;
    instr_t          e0 [7];
    instr_t          e1 [7];
    logic [NP-1:0]   ev [7];
    logic [TS_W-1:0] ets [7];
    logic [NP*IW-1:0] exp_i;
    do_reset();
    wa = mk(OP_1Q, 1, 1, 1, 0);    w30 = mk(OP_1Q, 2, 2, 2, 30);
    w20a = mk(OP_2Q, 3, 4, 4, 20); w20b = mk(OP_MEAS, 5, 5, 6, 20);
    w40 = mk(OP_1Q, 8, 8, 8, 40);
    drive(1'b1, wa, '0);   tick();
    drive(1'b1, w30, '0);  tick();
    drive(1'b1, w20a, '0); tick();
    drive(1'b1, w20b, '0); tick();
    drive(1'b1, w40, '0);  tick();
    n_tests++; if (bus.dsp_valid !== 4'b0001 || bus.dsp_instr[IW-1:0] !== wa) begin
      n_fail++; $display("FAIL order_hold got %b/%h want 0001/%h", bus.dsp_valid, bus.dsp_instr[IW-1:0], wa); end
    n_tests++; if (occ !== 5'd5) begin n_fail++; $display("FAIL order_occ got %0d want 5", occ); end
    ev  = '{4'b0000, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    ets = '{16'd0, 16'd20, 16'd20, 16'd30, 16'd30, 16'd40, 16'd40};
    e0  = '{'0, w20a, '0, w30, '0, w40, '0};
    e1  = '{'0, w20b, '0, '0, '0, '0, '0};
    drive(1'b0, '0, '1);
    for (int c = 0; c < 7; c++) begin
      tick();
      exp_i = '0;
      exp_i[0 +: IW]  = e0[c];
      exp_i[IW +: IW] = e1[c];
      n_tests++; if (bus.dsp_valid !== ev[c]) begin n_fail++; $display("FAIL order_valid c=%0d got %b want %b", c, bus.dsp_valid, ev[c]); end
      n_tests++; if (bus.dsp_instr !== exp_i) begin n_fail++; $display("FAIL order_instr c=%0d got %h want %h", c, bus.dsp_instr, exp_i); end
      n_tests++; if (curr_ts !== ets[c]) begin n_fail++; $display("FAIL order_ts c=%0d got %0d want %0d", c, curr_ts, ets[c]); end
    end
    n_tests++; if (busy !== 1'b0 || occ !== '0) begin n_fail++; $display("FAIL order_end got busy=%b occ=%0d want 0/0", busy, occ); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, mk(OP_1Q, i, i, i, 5), '0);
      tick();
    end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.in_ready); end
    n_tests++; if (occ !== 5'd16) begin n_fail++; $display("FAIL full_occ got %0d want 16", occ); end
    drive(1'b1, mk(OP_1Q, 99, 99, 99, 5), 4'b0001);
    tick();
    drive(1'b0, '0, '0);
    n_tests++; if (occ !== 5'd15) begin n_fail++; $display("FAIL full_free_occ got %0d want 15", occ); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got %b want 1", bus.in_ready); end
    n_tests++; if (bus.dsp_instr[IW-1:0] !== mk(OP_1Q, 1, 1, 1, 5)) begin
      n_fail++; $display("FAIL full_port0 got %h want %h", bus.dsp_instr[IW-1:0], mk(OP_1Q, 1, 1, 1, 5)); end
  endtask

  task automatic test_late();
    instr_t w40, w25;
    do_reset();
    w40 = mk(OP_MEAS, 2, 0, 0, 40);
    w25 = mk(OP_1Q, 3, 3, 3, 25);
    drive(1'b1, w40, '0); tick();
    drive(1'b0, '0, '0);  tick();
    n_tests++; if (bus.dsp_valid !== 4'b0001 || curr_ts !== 16'd40) begin
      n_fail++; $display("FAIL late_issue got %b ts=%0d want 0001 ts=40", bus.dsp_valid, curr_ts); end
    drive(1'b1, w25, '0); tick();
    drive(1'b0, '0, '0);
    n_tests++; if (bus.dsp_valid !== 4'b0011) begin n_fail++; $display("FAIL late_valid got %b want 0011", bus.dsp_valid); end
    n_tests++; if (bus.dsp_instr[IW +: IW] !== w25) begin n_fail++; $display("FAIL late_instr got %h want %h", bus.dsp_instr[IW +: IW], w25); end
    n_tests++; if (curr_ts !== 16'd40) begin n_fail++; $display("FAIL late_ts got %0d want 40", curr_ts); end
  endtask

  task automatic test_conflict();
    instr_t w1, w2;
    logic [NP*IW-1:0] exp_i;
    do_reset();
    w1 = mk(OP_2Q, 7, 1, 2, 0);
    w2 = mk(OP_1Q, 3, 7, 4, 0);
    drive(1'b1, w1, '1); tick();
    drive(1'b1, w2, '1); tick();
    drive(1'b0, '0, '1);
`ifdef QSCHED_QUBIT_CONFLICT_EN
    exp_i = '0; exp_i[0 +: IW] = w1;
    n_tests++; if (bus.dsp_valid !== 4'b0001 || bus.dsp_instr !== exp_i) begin
      n_fail++; $display("FAIL conflict_first got %b/%h want 0001/%h", bus.dsp_valid, bus.dsp_instr, exp_i); end
    tick();
    exp_i = '0; exp_i[0 +: IW] = w2;
    n_tests++; if (bus.dsp_valid !== 4'b0001 || bus.dsp_instr !== exp_i) begin
      n_fail++; $display("FAIL conflict_second got %b/%h want 0001/%h", bus.dsp_valid, bus.dsp_instr, exp_i); end
`else
    exp_i = '0; exp_i[0 +: IW] = w1; exp_i[IW +: IW] = w2;
    n_tests++; if (bus.dsp_valid !== 4'b0011 || bus.dsp_instr !== exp_i) begin
      n_fail++; $display("FAIL noconflict_pair got %b/%h want 0011/%h", bus.dsp_valid, bus.dsp_instr, exp_i); end
    tick();
    n_tests++; if (bus.dsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL noconflict_done got %b busy=%b want 0000 busy=0", bus.dsp_valid, busy); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, mk(OP_2Q, i, i + 8, i + 16, 50 + i), '0);
      tick();
    end
    n_tests++; if (occ !== 5'd6 || curr_ts !== 16'd50) begin
      n_fail++; $display("FAIL rstmid_pre got occ=%0d ts=%0d want 6/50", occ, curr_ts); end
    rst = 1'b1;
    drive(1'b0, '0, '1);
    tick();
    n_tests++; if (occ !== '0 || bus.dsp_valid !== '0 || curr_ts !== '0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_post got occ=%0d v=%b ts=%0d rdy=%b busy=%b want 0/0/0/1/0",
                         occ, bus.dsp_valid, curr_ts, bus.in_ready, busy); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    instr_t           mw [DEPTH];
    bit               mv [DEPTH];
    int               phase, cnt, occm, slot, tsi;
    int               pidx [NP];
    logic [TS_W-1:0]  mts, mn;
    bit               has, ok, left, any, iv, acc;
    logic [NP-1:0]    ev, rdy;
    logic [NP*IW-1:0] ei;
    instr_t           nw;
    do_reset();
    for (int e = 0; e < DEPTH; e++) begin mv[e] = 1'b0; mw[e] = '0; end
    phase = 0;
    mts   = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      occm = 0;
      foreach (mv[e]) if (mv[e]) occm++;
      ev = '0; ei = '0; cnt = 0;
      if (phase == 2) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (mv[e] && mw[e].start_time <= mts && cnt < NP) begin
            ok = 1'b1;
`ifdef QSCHED_QUBIT_CONFLICT_EN
            for (int q = 0; q < cnt; q++) if (tb_overlap(mw[pidx[q]], mw[e])) ok = 1'b0;
`endif
            if (ok) begin
              pidx[cnt] = e; ev[cnt] = 1'b1; ei[cnt*IW +: IW] = mw[e]; cnt++;
            end
          end
        end
      end
      n_tests++; if (bus.dsp_valid !== ev) begin n_fail++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, bus.dsp_valid, ev); end
      n_tests++; if (bus.dsp_instr !== ei) begin n_fail++; $display("FAIL rand_instr cyc=%0d got %h want %h", cyc, bus.dsp_instr, ei); end
      n_tests++; if (curr_ts !== mts) begin n_fail++; $display("FAIL rand_ts cyc=%0d got %0d want %0d", cyc, curr_ts, mts); end
      n_tests++; if (occ !== OW'(occm)) begin n_fail++; $display("FAIL rand_occ cyc=%0d got %0d want %0d", cyc, occ, occm); end
      n_tests++; if (bus.in_ready !== (occm < DEPTH)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, bus.in_ready, occm < DEPTH); end
      n_tests++; if (busy !== (phase != 0)) begin n_fail++; $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, phase != 0); end
      iv  = ($urandom_range(0, 3) != 0);
      tsi = int'(mts) + int'($urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0 && mts >= 16'd3) tsi = int'(mts) - 3;
      nw  = mk(op_code_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), tsi);
      rdy = ((cyc % 200) < 40) ? '0 : NP'($urandom_range(0, (1 << NP) - 1));
      drive(iv, nw, rdy);
      acc  = iv && (occm < DEPTH);
      slot = -1;
      has  = 1'b0;
      mn   = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (!mv[e] && slot < 0) slot = e;
        if (mv[e] && (!has || mw[e].start_time < mn)) begin mn = mw[e].start_time; has = 1'b1; end
      end
      for (int p = 0; p < cnt; p++) if (rdy[p]) mv[pidx[p]] = 1'b0;
      if (acc) begin mw[slot] = nw; mv[slot] = 1'b1; end
      left = 1'b0; any = 1'b0;
      foreach (mv[e]) begin
        if (mv[e]) any = 1'b1;
        if (mv[e] && mw[e].start_time <= mts) left = 1'b1;
      end
      if (phase == 0) phase = acc ? 1 : 0;
      else if (phase == 1) begin
        if (has && mn > mts) mts = mn;
        phase = 2;
      end else phase = left ? 2 : (any ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.dsp_ready = '0;
    test_reset();
    test_single();
    test_order();
    test_full();
    test_late();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
